// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants and types for the RAM port arbiter and its response FIFOs.
package ram_port_arbiter_pkg;

   localparam int unsigned RA_ADDR_W = 32;
   localparam int unsigned RA_DATA_W = 32;
   localparam int unsigned RA_BE_W   = 4;

   localparam int unsigned RA_RAM_LATENCY_DEF = 1;
   localparam int unsigned RA_RSP_DEPTH_DEF   = 2;
   localparam int unsigned RA_MAX_STREAK_DEF  = 4;

   localparam logic RA_OWNER_INST = 1'b0;
   localparam logic RA_OWNER_DATA = 1'b1;

   localparam logic [0:0] ST_DATA_PRI   = 1'b0;
   localparam logic [0:0] ST_INST_FORCE = 1'b1;

   typedef struct packed {
      logic valid;
      logic owner;
   } ra_tag_t;

   typedef struct packed {
      logic                 en;
      logic [RA_BE_W-1:0]   b_en;
      logic [RA_ADDR_W-1:0] addr;
      logic [RA_DATA_W-1:0] w_data;
   } ra_ram_req_t;

   // Pointer width that stays legal for a single-entry FIFO.
   function automatic int unsigned ra_clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Response FIFO with registered status; a same-cycle push and pop are both honoured.
module ram_rsp_fifo
   import ram_port_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = RA_RSP_DEPTH_DEF,
   parameter int unsigned WIDTH = RA_DATA_W
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   localparam int unsigned PW = ra_clog2_min1(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_pop = i_pop && (r_count != '0);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[PW'(i)] <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (i_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!i_push && w_pop) r_count <= r_count - CW'(1);
      end
   end

   assign o_valid = (r_count != '0);
   assign o_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one pipelined RAM port between fetch and data requesters: data priority,
// bounded fetch starvation, credit-protected response FIFOs per requester.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int unsigned RAM_LATENCY = RA_RAM_LATENCY_DEF,
   parameter int unsigned RSP_DEPTH   = RA_RSP_DEPTH_DEF,
   parameter int unsigned MAX_STREAK  = RA_MAX_STREAK_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_inst_req,
   input  logic [RA_ADDR_W-1:0] i_inst_addr,
   output logic                 o_inst_gnt,
   output logic                 o_inst_r_valid,
   output logic [RA_DATA_W-1:0] o_inst_r_data,
   input  logic                 i_inst_r_ready,
   input  logic                 i_data_req,
   input  logic [RA_BE_W-1:0]   i_data_b_en,
   input  logic [RA_ADDR_W-1:0] i_data_addr,
   input  logic [RA_DATA_W-1:0] i_data_w_data,
   output logic                 o_data_gnt,
   output logic                 o_data_r_valid,
   output logic [RA_DATA_W-1:0] o_data_r_data,
   input  logic                 i_data_r_ready,
   output logic                 o_ram_en,
   output logic [RA_BE_W-1:0]   o_ram_b_en,
   output logic [RA_ADDR_W-1:0] o_ram_addr,
   output logic [RA_DATA_W-1:0] o_ram_w_data,
   input  logic [RA_DATA_W-1:0] i_ram_r_data
);

   localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
   localparam int unsigned SW = $clog2(MAX_STREAK + 1);
   localparam int unsigned TW = $bits(ra_tag_t) * RAM_LATENCY;

   logic [0:0]                  r_state;
   logic [0:0]                  w_state_nxt;
   logic [SW-1:0]               r_streak;
   logic [SW-1:0]               w_streak_nxt;
   logic [CW-1:0]               r_inst_credit;
   logic [CW-1:0]               r_data_credit;
   ra_tag_t [RAM_LATENCY-1:0]   r_tag;
   ra_tag_t                     w_tag_in;
   ra_ram_req_t                 w_ram;
   logic w_data_wr, w_inst_elig, w_data_elig;
   logic w_inst_gnt, w_data_gnt, w_data_rd_gnt;
   logic w_inst_push, w_data_push, w_inst_pop, w_data_pop;

   assign w_data_wr   = (i_data_b_en != '0);
   assign w_inst_elig = i_inst_req && (r_inst_credit < CW'(RSP_DEPTH));
   assign w_data_elig = i_data_req && (w_data_wr || (r_data_credit < CW'(RSP_DEPTH)));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state  <= ST_DATA_PRI;
         r_streak <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_streak <= w_streak_nxt;
      end
   end

   // Grant selection, streak tracking and next state
   always_comb begin
      w_inst_gnt   = 1'b0;
      w_data_gnt   = 1'b0;
      w_streak_nxt = r_streak;
      w_state_nxt  = r_state;
      if (!i_reset) begin
         if (r_state == ST_INST_FORCE) begin
            w_inst_gnt = w_inst_elig;
            w_data_gnt = w_data_elig && !w_inst_elig;
         end else begin
            w_data_gnt = w_data_elig;
            w_inst_gnt = w_inst_elig && !w_data_elig;
         end
      end
      if (w_inst_gnt || !w_inst_elig) w_streak_nxt = '0;
      else if (w_data_gnt)            w_streak_nxt = r_streak + SW'(1);
      case (r_state)
         ST_DATA_PRI: if (w_streak_nxt == SW'(MAX_STREAK)) w_state_nxt = ST_INST_FORCE;
         default:     if (w_inst_gnt || !w_inst_elig)     w_state_nxt = ST_DATA_PRI;
      endcase
   end

   always_comb begin
      w_ram = '0;
      if (w_data_gnt) begin
         w_ram.en     = 1'b1;
         w_ram.b_en   = i_data_b_en;
         w_ram.addr   = i_data_addr;
         w_ram.w_data = i_data_w_data;
      end else if (w_inst_gnt) begin
         w_ram.en   = 1'b1;
         w_ram.addr = i_inst_addr;
      end
   end

   assign o_inst_gnt   = w_inst_gnt;
   assign o_data_gnt   = w_data_gnt;
   assign o_ram_en     = w_ram.en;
   assign o_ram_b_en   = w_ram.b_en;
   assign o_ram_addr   = w_ram.addr;
   assign o_ram_w_data = w_ram.w_data;

   // Tag pipeline follows each read through the RAM so its data lands in the right FIFO
   assign w_data_rd_gnt  = w_data_gnt && !w_data_wr;
   assign w_tag_in.valid = w_inst_gnt || w_data_rd_gnt;
   assign w_tag_in.owner = w_data_rd_gnt ? RA_OWNER_DATA : RA_OWNER_INST;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_tag <= '0;
      else         r_tag <= TW'({r_tag, w_tag_in});
   end

   assign w_inst_push = r_tag[RAM_LATENCY-1].valid && (r_tag[RAM_LATENCY-1].owner == RA_OWNER_INST);
   assign w_data_push = r_tag[RAM_LATENCY-1].valid && (r_tag[RAM_LATENCY-1].owner == RA_OWNER_DATA);
   assign w_inst_pop  = o_inst_r_valid && i_inst_r_ready;
   assign w_data_pop  = o_data_r_valid && i_data_r_ready;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_inst_credit <= '0;
         r_data_credit <= '0;
      end else begin
         if (w_inst_gnt && !w_inst_pop)      r_inst_credit <= r_inst_credit + CW'(1);
         else if (!w_inst_gnt && w_inst_pop) r_inst_credit <= r_inst_credit - CW'(1);
         if (w_data_rd_gnt && !w_data_pop)      r_data_credit <= r_data_credit + CW'(1);
         else if (!w_data_rd_gnt && w_data_pop) r_data_credit <= r_data_credit - CW'(1);
      end
   end

   ram_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(RA_DATA_W)) u_inst_fifo (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_push      (w_inst_push),
      .i_push_data (i_ram_r_data),
      .i_pop       (i_inst_r_ready),
      .o_valid     (o_inst_r_valid),
      .o_data      (o_inst_r_data)
   );

   ram_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(RA_DATA_W)) u_data_fifo (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_push      (w_data_push),
      .i_push_data (i_ram_r_data),
      .i_pop       (i_data_r_ready),
      .o_valid     (o_data_r_valid),
      .o_data      (o_data_r_data)
   );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: a default-parameter arbiter and a RAM_LATENCY=3 / RSP_DEPTH=4 arbiter
// share the request inputs, each with its own behavioural RAM.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, inst_r_ready, data_req, data_r_ready;
   logic [31:0] inst_addr, data_addr, data_w_data;
   logic [3:0]  data_b_en;

   logic        inst_gnt1, inst_r_valid1, data_gnt1, data_r_valid1, ram_en1;
   logic [31:0] inst_r_data1, data_r_data1, ram_addr1, ram_w_data1, ram_r_data1;
   logic [3:0]  ram_b_en1;
   logic        inst_gnt3, inst_r_valid3, data_gnt3, data_r_valid3, ram_en3;
   logic [31:0] inst_r_data3, data_r_data3, ram_addr3, ram_w_data3, ram_r_data3;
   logic [3:0]  ram_b_en3;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ram_port_arbiter u_dut1 (
      .i_clk(clk), .i_reset(rst),
      .i_inst_req(inst_req), .i_inst_addr(inst_addr), .o_inst_gnt(inst_gnt1),
      .o_inst_r_valid(inst_r_valid1), .o_inst_r_data(inst_r_data1), .i_inst_r_ready(inst_r_ready),
      .i_data_req(data_req), .i_data_b_en(data_b_en), .i_data_addr(data_addr),
      .i_data_w_data(data_w_data), .o_data_gnt(data_gnt1),
      .o_data_r_valid(data_r_valid1), .o_data_r_data(data_r_data1), .i_data_r_ready(data_r_ready),
      .o_ram_en(ram_en1), .o_ram_b_en(ram_b_en1), .o_ram_addr(ram_addr1),
      .o_ram_w_data(ram_w_data1), .i_ram_r_data(ram_r_data1)
   );

   ram_port_arbiter #(.RAM_LATENCY(3), .RSP_DEPTH(4), .MAX_STREAK(4)) u_dut3 (
      .i_clk(clk), .i_reset(rst),
      .i_inst_req(inst_req), .i_inst_addr(inst_addr), .o_inst_gnt(inst_gnt3),
      .o_inst_r_valid(inst_r_valid3), .o_inst_r_data(inst_r_data3), .i_inst_r_ready(inst_r_ready),
      .i_data_req(data_req), .i_data_b_en(data_b_en), .i_data_addr(data_addr),
      .i_data_w_data(data_w_data), .o_data_gnt(data_gnt3),
      .o_data_r_valid(data_r_valid3), .o_data_r_data(data_r_data3), .i_data_r_ready(data_r_ready),
      .o_ram_en(ram_en3), .o_ram_b_en(ram_b_en3), .o_ram_addr(ram_addr3),
      .o_ram_w_data(ram_w_data3), .i_ram_r_data(ram_r_data3)
   );

   // Behavioural RAMs: word at address a defaults to ~a, except 0x100 holds 0xDEADBEEF
   logic [31:0] mem1 [4096];
   logic [31:0] mem3 [4096];
   logic [31:0] rd1_q;
   logic [31:0] rd3_q [3];

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4096; i++) mem1[12'(i)] <= (i == 256) ? 32'hDEADBEEF : ~32'(i);
      end else if (ram_en1) begin
         if (ram_b_en1 == 4'd0) rd1_q <= mem1[ram_addr1[11:0]];
         else mem1[ram_addr1[11:0]] <= merge(mem1[ram_addr1[11:0]], ram_w_data1, ram_b_en1);
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4096; i++) mem3[12'(i)] <= (i == 256) ? 32'hDEADBEEF : ~32'(i);
      end else if (ram_en3 && ram_b_en3 != 4'd0) begin
         mem3[ram_addr3[11:0]] <= merge(mem3[ram_addr3[11:0]], ram_w_data3, ram_b_en3);
      end
      rd3_q[0] <= (ram_en3 && ram_b_en3 == 4'd0) ? mem3[ram_addr3[11:0]] : 32'h0;
      rd3_q[1] <= rd3_q[0];
      rd3_q[2] <= rd3_q[1];
   end

   assign ram_r_data1 = rd1_q;
   assign ram_r_data3 = rd3_q[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      inst_req    = 1'b0;
      inst_addr   = 32'h0;
      data_req    = 1'b0;
      data_b_en   = 4'h0;
      data_addr   = 32'h0;
      data_w_data = 32'h0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      inst_r_ready = 1'b1;
      data_r_ready = 1'b1;
      inst_req  = 1'b1;
      inst_addr = 32'h100;
      data_req  = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_inst_gnt", inst_gnt1, 0);
      chk("rst_data_gnt", data_gnt1, 0);
      chk("rst_ram_en", ram_en1, 0);
      chk("rst_ram_addr", ram_addr1, 0);
      chk("rst_inst_r_valid", inst_r_valid1, 0);
      chk("rst_data_r_valid", data_r_valid1, 0);
      chk("rst_inst_r_data", inst_r_data1, 0);
      chk("rst_data_r_data", data_r_data1, 0);
      chk("rst_ram_en3", ram_en3, 0);

      // Single fetch read, LAT=1
      @(negedge clk); rst = 1'b0; idle(); inst_req = 1'b1; inst_addr = 32'h100; #1;
      chk("t1_inst_gnt", inst_gnt1, 1);
      chk("t1_data_gnt", data_gnt1, 0);
      chk("t1_ram_addr", ram_addr1, 32'h100);
      chk("t1_ram_b_en", ram_b_en1, 0);
      @(negedge clk); idle(); #1;
      chk("t1_early_valid", inst_r_valid1, 0);
      @(negedge clk); #1;
      chk("t1_inst_r_valid", inst_r_valid1, 1);
      chk("t1_inst_r_data", inst_r_data1, 32'hDEADBEEF);
      chk("t1_data_r_valid", data_r_valid1, 0);
      @(negedge clk); #1;
      chk("t1_popped", inst_r_valid1, 0);

      // Both request every cycle (data writes, fetch reads): D D D D I repeating
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         inst_req = 1'b1; inst_addr = 32'h180 + 32'(i);
         data_req = 1'b1; data_b_en = 4'hF; data_addr = 32'h200 + 32'(i); data_w_data = 32'(i);
         #1;
         chk("t2_inst_gnt", inst_gnt1, (i % 5 == 4));
         chk("t2_data_gnt", data_gnt1, (i % 5 != 4));
      end
      @(negedge clk); idle();
      repeat (3) @(negedge clk);

      // Backpressure: credits stop data reads at RSP_DEPTH=2
      data_r_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         data_req = 1'b1; data_b_en = 4'h0; data_addr = 32'h300 + 32'((i < 2) ? i : 2);
         #1;
         chk("t3_data_gnt", data_gnt1, (i < 2));
      end
      @(negedge clk); idle(); #1;
      chk("t3_hold_valid", data_r_valid1, 1);
      chk("t3_hold_data", data_r_data1, ~32'h300);
      chk("t3_hold_gnt", data_gnt1, 0);
      @(negedge clk); data_r_ready = 1'b1; #1;
      chk("t3_first_data", data_r_data1, ~32'h300);
      @(negedge clk); #1;
      chk("t3_second_valid", data_r_valid1, 1);
      chk("t3_second_data", data_r_data1, ~32'h301);
      @(negedge clk); data_req = 1'b1; data_addr = 32'h3A0; #1;
      chk("t3_drained", data_r_valid1, 0);
      chk("t3_regrant", data_gnt1, 1);
      @(negedge clk); idle();
      @(negedge clk); #1;
      chk("t3_new_data", data_r_data1, ~32'h3A0);
      @(negedge clk);

      // Store while data credits are full
      data_r_ready = 1'b0;
      data_req = 1'b1; data_b_en = 4'h0; data_addr = 32'h400; #1;
      chk("t4_rd0_gnt", data_gnt1, 1);
      @(negedge clk); data_addr = 32'h401; #1;
      chk("t4_rd1_gnt", data_gnt1, 1);
      @(negedge clk); data_b_en = 4'b0011; data_addr = 32'h410; data_w_data = 32'h12345678; #1;
      chk("t4_wr_gnt", data_gnt1, 1);
      chk("t4_wr_ram_en", ram_en1, 1);
      chk("t4_wr_b_en", ram_b_en1, 4'b0011);
      chk("t4_wr_addr", ram_addr1, 32'h410);
      chk("t4_wr_data", ram_w_data1, 32'h12345678);
      @(negedge clk); idle(); data_r_ready = 1'b1; #1;
      chk("t4_rsp0", data_r_data1, ~32'h400);
      @(negedge clk); #1;
      chk("t4_rsp1", data_r_data1, ~32'h401);
      @(negedge clk); #1;
      chk("t4_no_wr_rsp_a", data_r_valid1, 0);
      @(negedge clk); #1;
      chk("t4_no_wr_rsp_b", data_r_valid1, 0);
      @(negedge clk); data_req = 1'b1; data_addr = 32'h410; #1;
      chk("t4_rb_gnt", data_gnt1, 1);
      @(negedge clk); idle();
      @(negedge clk); #1;
      chk("t4_rb_data", data_r_data1, 32'hFFFF5678);

      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;

      // LAT=3 alternating fetch/data reads, responses 4 cycles after grant
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         idle();
         if (i < 6) begin
            if (i % 2 == 0) begin
               inst_req = 1'b1; inst_addr = 32'h500 + 32'(i);
            end else begin
               data_req = 1'b1; data_addr = 32'h600 + 32'(i);
            end
         end
         #1;
         if (i < 6) begin
            chk("t5_inst_gnt", inst_gnt3, (i % 2 == 0));
            chk("t5_data_gnt", data_gnt3, (i % 2 == 1));
         end
         if (i >= 4) begin
            if ((i - 4) % 2 == 0) begin
               chk("t5_inst_valid", inst_r_valid3, 1);
               chk("t5_inst_data", inst_r_data3, ~(32'h500 + 32'(i - 4)));
               chk("t5_data_idle", data_r_valid3, 0);
            end else begin
               chk("t5_data_valid", data_r_valid3, 1);
               chk("t5_data_data", data_r_data3, ~(32'h600 + 32'(i - 4)));
               chk("t5_inst_idle", inst_r_valid3, 0);
            end
         end
      end
      @(negedge clk);

      // Reset with reads in flight
      data_req = 1'b1; data_addr = 32'h700;
      @(negedge clk); idle(); inst_req = 1'b1; inst_addr = 32'h710;
      @(negedge clk); rst = 1'b1; data_req = 1'b1; data_addr = 32'h720; #1;
      chk("t6_inst_gnt1", inst_gnt1, 0);
      chk("t6_data_gnt1", data_gnt1, 0);
      chk("t6_ram_en1", ram_en1, 0);
      chk("t6_ram_addr1", ram_addr1, 0);
      chk("t6_data_r_valid1", data_r_valid1, 0);
      chk("t6_data_r_data1", data_r_data1, 0);
      chk("t6_ram_en3", ram_en3, 0);
      chk("t6_inst_gnt3", inst_gnt3, 0);
      @(negedge clk); rst = 1'b0; idle();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         chk("t6_inst_valid1", inst_r_valid1, 0);
         chk("t6_data_valid1", data_r_valid1, 0);
         chk("t6_inst_valid3", inst_r_valid3, 0);
         chk("t6_data_valid3", data_r_valid3, 0);
      end
      data_r_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); data_req = 1'b1; data_addr = 32'h800; #1;
         chk("t6_credit_gnt1", data_gnt1, (i < 2));
         chk("t6_credit_gnt3", data_gnt3, (i < 4));
      end
      @(negedge clk); idle(); data_r_ready = 1'b1;
      repeat (6) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
